// File: rtl/proc_pipe_pckg.sv
// rtl/proc_pipe_pckg.sv - shared pipeline types and write-back FIFO sizing constants
package proc_pipe_pckg;

    localparam int C_PIPE_DATA_WDT = 32;

    typedef enum logic [1:0] {
        VECT_TYPE_FEAT = 2'd0,
        VECT_TYPE_BIAS = 2'd1,
        VECT_TYPE_PSUM = 2'd2,
        VECT_TYPE_CTRL = 2'd3
    } pipe_data_vect_type_e;

    typedef struct packed {
        logic                       data_vect_val;
        logic                       data_vect_last;
        pipe_data_vect_type_e       data_vect_type;
        logic [C_PIPE_DATA_WDT-1:0] data_vect_data;
    } pipe_data_vect_t;

    localparam int              C_PIPE_DATA_VECT_WDT     = $bits(pipe_data_vect_t);
    localparam pipe_data_vect_t C_PIPE_DATA_VECT_RST_VAL = '0;

    localparam int C_MAXPOOL_IN_DEL_CYC_LEN   = 1;
    localparam int C_MAXPOOL_ACC_COMP_CYC_LEN = 1;
    localparam int C_MAXPOOL_OUT_DEL_CYC_LEN  = 1;

    // vectors that can still arrive after a stall request is raised
    localparam int C_MAXPOOL_INFLIGHT = C_MAXPOOL_IN_DEL_CYC_LEN + C_MAXPOOL_ACC_COMP_CYC_LEN
                                        + C_MAXPOOL_OUT_DEL_CYC_LEN + 1;

    localparam int C_PIPE_WB_FIFO_DEPTH     = 16;
    localparam int C_PIPE_WB_FIFO_AFULL_THR = C_PIPE_WB_FIFO_DEPTH - C_MAXPOOL_INFLIGHT;

endpackage

// File: rtl/pipe_wb_fifo_if.sv
// rtl/pipe_wb_fifo_if.sv - maxpool-side and write-back-side handshake bundle
interface pipe_wb_fifo_if;
    import proc_pipe_pckg::*;

    logic            wb_in_step;
    pipe_data_vect_t wb_in_vect;
    logic            wb_stall_req;
    pipe_data_vect_t wb_out_vect;
    logic            wb_out_val;
    logic            wb_out_rdy;
    logic            wb_last_done;

    modport master (
        output wb_in_step,
        output wb_in_vect,
        input  wb_stall_req,
        input  wb_out_vect,
        input  wb_out_val,
        output wb_out_rdy,
        input  wb_last_done
    );

    modport slave (
        input  wb_in_step,
        input  wb_in_vect,
        output wb_stall_req,
        output wb_out_vect,
        output wb_out_val,
        input  wb_out_rdy,
        output wb_last_done
    );

endinterface

// File: rtl/pipe_wb_fifo_mem.sv
// rtl/pipe_wb_fifo_mem.sv - simple dual-port vector array with registered write-first read
module wb_fifo_mem
    import proc_pipe_pckg::*;
#(
    parameter int DEPTH = C_PIPE_WB_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  pipe_data_vect_t          wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output pipe_data_vect_t          rd_data
);

    pipe_data_vect_t mem [DEPTH];

    // write port; array contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // read register doubles as the FIFO head; same-address write is forwarded so a push into an empty FIFO shows up next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= C_PIPE_DATA_VECT_RST_VAL;
        end else if (rd_en) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/pipe_wb_fifo.sv
// rtl/pipe_wb_fifo.sv - elastic write-back FIFO after maxpool; PIPE_WB_FIFO_STATS_EN adds wb_level_max
module pipe_wb_fifo
    import proc_pipe_pckg::*;
#(
    parameter int DEPTH     = C_PIPE_WB_FIFO_DEPTH,
    parameter int AFULL_THR = DEPTH - C_MAXPOOL_INFLIGHT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_clear,
    pipe_wb_fifo_if.slave              wb,
    output logic                       wb_ovf,
    output logic [$clog2(DEPTH+1)-1:0] wb_level
`ifdef PIPE_WB_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] wb_level_max
`endif
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    logic [LW-1:0] arr_cnt;
    logic          out_val_q;
    logic          ovf_q;
    logic          stall_q;
    logic          last_done_q;
    logic          push;
    logic          pop;
    logic          push_acc;
    logic          drop;
    logic          load;

    // handshake decode: level counts array entries plus the head register
    always_comb begin
        push      = wb.wb_in_step & wb.wb_in_vect.data_vect_val;
        pop       = out_val_q & wb.wb_out_rdy;
        push_acc  = push & ((level_q != LW'(DEPTH)) | pop);
        drop      = push & ~push_acc;
        arr_cnt   = level_q - {{(LW-1){1'b0}}, out_val_q};
        load      = (~out_val_q | pop) & ((arr_cnt != '0) | push_acc);
        level_nxt = level_q + {{(LW-1){1'b0}}, push_acc} - {{(LW-1){1'b0}}, pop};
    end

    // pointers, occupancy, head-valid and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_val_q   <= 1'b0;
            ovf_q       <= 1'b0;
            stall_q     <= 1'b0;
            last_done_q <= 1'b0;
        end else if (wb_clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_val_q   <= 1'b0;
            ovf_q       <= 1'b0;
            stall_q     <= 1'b0;
            last_done_q <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (load) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            level_q     <= level_nxt;
            out_val_q   <= load | (out_val_q & ~pop);
            stall_q     <= (level_nxt >= LW'(AFULL_THR));
            last_done_q <= pop & wb.wb_out_vect.data_vect_last;
        end
    end

    wb_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_acc & ~wb_clear),
        .wr_addr (wr_ptr_q),
        .wr_data (wb.wb_in_vect),
        .rd_en   (load & ~wb_clear),
        .rd_addr (rd_ptr_q),
        .rd_data (wb.wb_out_vect)
    );

    assign wb.wb_out_val   = out_val_q;
    assign wb.wb_stall_req = stall_q;
    assign wb.wb_last_done = last_done_q;
    assign wb_ovf          = ovf_q;
    assign wb_level        = level_q;

`ifdef PIPE_WB_FIFO_STATS_EN
    logic [LW-1:0] level_max_q;

    // high-water mark of occupancy since reset or clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_max_q <= '0;
        end else if (wb_clear) begin
            level_max_q <= '0;
        end else if (level_nxt > level_max_q) begin
            level_max_q <= level_nxt;
        end
    end

    assign wb_level_max = level_max_q;
`endif

endmodule

// File: tb/tb_pipe_wb_fifo.sv
// tb/tb_pipe_wb_fifo.sv - directed self-checking bench for pipe_wb_fifo
module tb_pipe_wb_fifo;
    import proc_pipe_pckg::*;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_clear;
    logic          wb_ovf;
    logic [LW-1:0] wb_level;
`ifdef PIPE_WB_FIFO_STATS_EN
    logic [LW-1:0] wb_level_max;
`endif

    int total = 0;
    int bad   = 0;

    pipe_wb_fifo_if wb_if ();

    pipe_wb_fifo #(
        .DEPTH     (DEPTH),
        .AFULL_THR (12)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_clear (wb_clear),
        .wb       (wb_if),
        .wb_ovf   (wb_ovf),
        .wb_level (wb_level)
`ifdef PIPE_WB_FIFO_STATS_EN
        ,
        .wb_level_max (wb_level_max)
`endif
    );

    always #5 clk = ~clk;

    function automatic pipe_data_vect_t mkv(input logic [31:0] d, input logic last);
        pipe_data_vect_t v;
        v.data_vect_val  = 1'b1;
        v.data_vect_last = last;
        v.data_vect_type = pipe_data_vect_type_e'(d[1:0]);
        v.data_vect_data = d;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_clear             = 1'b0;
        wb_if.wb_in_step     = 1'b0;
        wb_if.wb_in_vect     = '0;
        wb_if.wb_out_rdy     = 1'b0;
    endtask

    task automatic clear_fifo();
        idle();
        wb_clear = 1'b1;
        tick();
        wb_clear = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] d, input logic last);
        wb_if.wb_in_step = 1'b1;
        wb_if.wb_in_vect = mkv(d, last);
        tick();
        wb_if.wb_in_step = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        total++; if (wb_level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", wb_level); end
        total++; if (wb_if.wb_out_val !== 1'b0) begin bad++; $display("FAIL reset_out_val got=%b exp=0", wb_if.wb_out_val); end
        total++; if (wb_if.wb_out_vect !== C_PIPE_DATA_VECT_RST_VAL) begin bad++; $display("FAIL reset_out_vect got=%h exp=0", wb_if.wb_out_vect); end
        total++; if ({wb_if.wb_stall_req, wb_ovf, wb_if.wb_last_done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {wb_if.wb_stall_req, wb_ovf, wb_if.wb_last_done}); end
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_held_input();
        logic [31:0] got [$];
        clear_fifo();
        wb_if.wb_out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_if.wb_in_step = 1'b1;
            wb_if.wb_in_vect = mkv(32'h10 + i, 1'b0);
            tick();
            if (i == 0) begin
                total++; if (wb_if.wb_out_val !== 1'b1 || wb_if.wb_out_vect.data_vect_data !== 32'h10) begin
                    bad++; $display("FAIL held_first_latency got val=%b data=%h exp val=1 data=10", wb_if.wb_out_val, wb_if.wb_out_vect.data_vect_data);
                end
            end
            if (wb_if.wb_out_val) got.push_back(wb_if.wb_out_vect.data_vect_data);
        end
        wb_if.wb_in_step = 1'b0;
        wb_if.wb_in_vect = mkv(32'h99, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wb_if.wb_out_val) got.push_back(wb_if.wb_out_vect.data_vect_data);
        end
        total++; if (got.size() !== 3) begin bad++; $display("FAIL held_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++; if (got[i] !== 32'h10 + i) begin bad++; $display("FAIL held_order[%0d] got=%h exp=%h", i, got[i], 32'h10 + i); end
        end
        total++; if (wb_level !== '0) begin bad++; $display("FAIL held_level_end got=%0d exp=0", wb_level); end
        idle();
    endtask

    task automatic test_stall();
        clear_fifo();
        for (int i = 1; i <= 12; i++) begin
            push_one(32'h200 + i, 1'b0);
            if (i == 11) begin
                total++; if (wb_if.wb_stall_req !== 1'b0) begin bad++; $display("FAIL stall_at_11 got=%b exp=0", wb_if.wb_stall_req); end
            end
        end
        total++; if (wb_if.wb_stall_req !== 1'b1 || wb_level !== 12) begin
            bad++; $display("FAIL stall_at_12 got stall=%b level=%0d exp stall=1 level=12", wb_if.wb_stall_req, wb_level);
        end
        wb_if.wb_out_rdy = 1'b1;
        tick();
        wb_if.wb_out_rdy = 1'b0;
        total++; if (wb_if.wb_stall_req !== 1'b0 || wb_level !== 11) begin
            bad++; $display("FAIL stall_after_pop got stall=%b level=%0d exp stall=0 level=11", wb_if.wb_stall_req, wb_level);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_d;
        clear_fifo();
        for (int i = 0; i < 16; i++) push_one(32'h100 + i, 1'b0);
        total++; if (wb_level !== 16 || wb_ovf !== 1'b0) begin bad++; $display("FAIL ovf_full got level=%0d ovf=%b exp level=16 ovf=0", wb_level, wb_ovf); end
        push_one(32'h1ff, 1'b0);
        total++; if (wb_level !== 16 || wb_ovf !== 1'b1) begin bad++; $display("FAIL ovf_drop got level=%0d ovf=%b exp level=16 ovf=1", wb_level, wb_ovf); end
        total++; if (wb_if.wb_out_vect.data_vect_data !== 32'h100) begin bad++; $display("FAIL ovf_head got=%h exp=100", wb_if.wb_out_vect.data_vect_data); end
        wb_if.wb_out_rdy = 1'b1;
        push_one(32'h200, 1'b0);
        total++; if (wb_level !== 16 || wb_ovf !== 1'b1) begin bad++; $display("FAIL ovf_pushpop got level=%0d ovf=%b exp level=16 ovf=1", wb_level, wb_ovf); end
        for (int j = 0; j < 16; j++) begin
            exp_d = (j < 15) ? 32'h101 + j : 32'h200;
            total++; if (wb_if.wb_out_val !== 1'b1 || wb_if.wb_out_vect.data_vect_data !== exp_d) begin
                bad++; $display("FAIL ovf_drain[%0d] got val=%b data=%h exp val=1 data=%h", j, wb_if.wb_out_val, wb_if.wb_out_vect.data_vect_data, exp_d);
            end
            tick();
        end
        total++; if (wb_level !== '0 || wb_if.wb_out_val !== 1'b0) begin bad++; $display("FAIL ovf_empty got level=%0d val=%b exp 0 0", wb_level, wb_if.wb_out_val); end
        clear_fifo();
        total++; if (wb_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", wb_ovf); end
    endtask

    task automatic test_last();
        int          rdy_seq [4] = '{1, 0, 1, 1};
        int          val_exp [4] = '{1, 1, 1, 0};
        logic [31:0] dat_exp [4] = '{32'hb0, 32'hb0, 32'hc0, 32'h0};
        int          ld_exp  [4] = '{0, 0, 0, 1};
        int          pulses = 0;
        clear_fifo();
        push_one(32'ha0, 1'b0);
        push_one(32'hb0, 1'b0);
        push_one(32'hc0, 1'b1);
        total++; if (wb_if.wb_out_vect.data_vect_data !== 32'ha0 || wb_if.wb_last_done !== 1'b0) begin
            bad++; $display("FAIL last_head got=%h ld=%b exp=a0 ld=0", wb_if.wb_out_vect.data_vect_data, wb_if.wb_last_done);
        end
        for (int k = 0; k < 4; k++) begin
            wb_if.wb_out_rdy = (rdy_seq[k] != 0);
            tick();
            if (wb_if.wb_last_done) pulses++;
            total++; if (wb_if.wb_out_val !== (val_exp[k] != 0) || wb_if.wb_last_done !== (ld_exp[k] != 0)) begin
                bad++; $display("FAIL last_step[%0d] got val=%b ld=%b exp val=%0d ld=%0d", k, wb_if.wb_out_val, wb_if.wb_last_done, val_exp[k], ld_exp[k]);
            end
            if (val_exp[k] != 0) begin
                total++; if (wb_if.wb_out_vect.data_vect_data !== dat_exp[k]) begin
                    bad++; $display("FAIL last_data[%0d] got=%h exp=%h", k, wb_if.wb_out_vect.data_vect_data, dat_exp[k]);
                end
            end
        end
        wb_if.wb_out_rdy = 1'b0;
        tick();
        if (wb_if.wb_last_done) pulses++;
        total++; if (pulses !== 1) begin bad++; $display("FAIL last_pulse_count got=%0d exp=1", pulses); end
    endtask

    task automatic test_clear_reset();
        clear_fifo();
        for (int i = 0; i < 5; i++) push_one(32'h300 + i, 1'b0);
        total++; if (wb_level !== 5) begin bad++; $display("FAIL clr_level5 got=%0d exp=5", wb_level); end
        wb_clear         = 1'b1;
        wb_if.wb_in_step = 1'b1;
        wb_if.wb_in_vect = mkv(32'h3ff, 1'b0);
        tick();
        wb_clear         = 1'b0;
        wb_if.wb_in_step = 1'b0;
        total++; if (wb_level !== '0 || wb_if.wb_out_val !== 1'b0 || wb_ovf !== 1'b0) begin
            bad++; $display("FAIL clr_push got level=%0d val=%b ovf=%b exp 0 0 0", wb_level, wb_if.wb_out_val, wb_ovf);
        end
        tick();
        total++; if (wb_level !== '0 || wb_if.wb_out_val !== 1'b0) begin bad++; $display("FAIL clr_settle got level=%0d val=%b exp 0 0", wb_level, wb_if.wb_out_val); end
        for (int i = 0; i < 17; i++) push_one(32'h400 + i, 1'b1);
        total++; if (wb_ovf !== 1'b1 || wb_if.wb_stall_req !== 1'b1) begin bad++; $display("FAIL rst_pre got ovf=%b stall=%b exp 1 1", wb_ovf, wb_if.wb_stall_req); end
        wb_if.wb_out_rdy = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (wb_level !== '0 || wb_if.wb_out_val !== 1'b0 || wb_if.wb_out_vect !== C_PIPE_DATA_VECT_RST_VAL) begin
            bad++; $display("FAIL rst_mid_data got level=%0d val=%b vect=%h exp 0 0 0", wb_level, wb_if.wb_out_val, wb_if.wb_out_vect);
        end
        total++; if ({wb_if.wb_stall_req, wb_ovf, wb_if.wb_last_done} !== 3'b000) begin
            bad++; $display("FAIL rst_mid_flags got=%b exp=000", {wb_if.wb_stall_req, wb_ovf, wb_if.wb_last_done});
        end
        idle();
        tick();
        #4;
        rst_n = 1'b1;
        tick();
    endtask

`ifdef PIPE_WB_FIFO_STATS_EN
    task automatic test_stats();
        clear_fifo();
        for (int i = 0; i < 9; i++) push_one(32'h500 + i, 1'b0);
        wb_if.wb_out_rdy = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        wb_if.wb_out_rdy = 1'b0;
        total++; if (wb_level !== '0 || wb_level_max !== 9) begin bad++; $display("FAIL stats_max got level=%0d max=%0d exp 0 9", wb_level, wb_level_max); end
        clear_fifo();
        total++; if (wb_level_max !== '0) begin bad++; $display("FAIL stats_clear got=%0d exp=0", wb_level_max); end
    endtask
`endif

    initial begin
        test_reset();
        test_held_input();
        test_stall();
        test_overflow();
        test_last();
        test_clear_reset();
`ifdef PIPE_WB_FIFO_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_wb_fifo.md
# pipe_wb_fifo

Elastic write-back buffer directly downstream of the maxpool stage in the processing pipeline. Captures every valid `pipe_data_vect_t` the maxpool stage emits under pipeline step, stores it in a FIFO, and presents it to the tensor-memory write-back port over a valid/ready handshake. Raises a stall request before it can overflow, so the pipeline controller freezes the upstream stages while write-back is back-pressured.

## Interface

Parameters:
- `DEPTH`, default 16: number of vector entries. Must be a power of two and ≥ 4.
- `AFULL_THR`, default `DEPTH-4`: occupancy at or above which `wb_stall_req` asserts. Must be ≥ 1 and ≤ `DEPTH-1`. The headroom must cover upstream in-flight vectors.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous reset, active-low.
- `wb_clear`, in, 1: synchronous flush from the pipeline controller.
- `wb_in_step`, in, 1: upstream pipeline step; input is sampled only when this is high.
- `wb_in_vect`, in, `C_PIPE_DATA_VECT_WDT`: `pipe_data_vect_t` from the maxpool stage output.
- `wb_stall_req`, out, 1: occupancy ≥ `AFULL_THR`.
- `wb_out_vect`, out, `C_PIPE_DATA_VECT_WDT`: head vector.
- `wb_out_val`, out, 1: head vector valid.
- `wb_out_rdy`, in, 1: write-back consumer ready.
- `wb_last_done`, out, 1: one-cycle pulse when a vector with `data_vect_last` is popped.
- `wb_ovf`, out, 1: sticky overflow flag.
- `wb_level`, out, `$clog2(DEPTH+1)`: current occupancy.
- `wb_level_max`, out, `$clog2(DEPTH+1)`: present only with `PIPE_WB_FIFO_STATS_EN`.

## Operation

- **Push:** `push = wb_in_step & wb_in_vect.data_vect_val`. Vectors presented while step is low are ignored, so a held maxpool output is never duplicated.
- **Pop:** `pop = wb_out_val & wb_out_rdy`.
- **Storage:** circular array with read and write pointers of width `$clog2(DEPTH)`. Pointers wrap modulo `DEPTH`. Occupancy is held in a separate counter.
- **Full:**
  - A push while `level==DEPTH` with no simultaneous pop is dropped; `wb_ovf` is set and held until reset or clear.
  - Push and pop together while full are both accepted; level is unchanged.
- **Empty:**
  - A pop is impossible because `wb_out_val` is low.
  - Push and pop together while empty cannot occur because the output is registered; see Timing.
- **Stall request:** `wb_stall_req` is registered and reflects `level ≥ AFULL_THR` after the current cycle's push/pop.
- **Clear:** `wb_clear` resets pointers, level, `wb_out_val`, `wb_ovf` and `wb_level_max` to 0 on the next edge. It overrides any push or pop in the same cycle. Array contents are not cleared.
- **Data:** vector contents, type, last and val fields pass unmodified. The FIFO does not filter by `data_vect_type`.
- **Last pulse:** `wb_last_done` is registered and asserts the cycle after a pop whose vector has `data_vect_last=1`.

## Timing

- **Reset values:** all outputs are 0. `wb_out_vect` resets to `C_PIPE_DATA_VECT_RST_VAL`.
- **Latency:**
  - A push into an empty FIFO gives `wb_out_val=1` with that vector one cycle after the push edge.
  - With a continuously ready consumer, throughput is 1 vector per cycle.
- **Output register:** the head is held in an output register.
  - When the register is empty or being popped and the array is non-empty, the next entry loads.
  - `wb_out_vect` is stable while `wb_out_val & !wb_out_rdy`.
- **Level:** `wb_level` counts array entries plus the output-register entry and updates on the edge following a push or pop.
- **Reset mid-operation:** asynchronous `rst_n` low immediately forces all outputs to reset values. Data in flight is lost.

## Configuration

- **`PIPE_WB_FIFO_STATS_EN` defined:** `wb_level_max` records the high-water mark of `wb_level` since reset or clear. It is monotonic non-decreasing between clears.
- **Not defined:** the port and its register are absent. All other behaviour is identical.

## Structure

- **Shared package `proc_pipe_pckg`:**
  - Constants `C_PIPE_WB_FIFO_DEPTH` and `C_PIPE_WB_FIFO_AFULL_THR`. The threshold is derived as `DEPTH - (C_MAXPOOL_IN_DEL_CYC_LEN + C_MAXPOOL_ACC_COMP_CYC_LEN + C_MAXPOOL_OUT_DEL_CYC_LEN + 1)` to cover maxpool in-flight latency.
  - Existing types reused: `pipe_data_vect_t` and `C_PIPE_DATA_VECT_RST_VAL`.
- **Sub-module `wb_fifo_mem`:** simple dual-port array (one write port, one read port, synchronous read) holding the vectors. Pointer, level and handshake control stay in the top module.

## Test plan

1. **Held input:** push 3 vectors with step high, then hold a valid input with step low for 5 cycles, `wb_out_rdy=1` → exactly 3 vectors out, in order, first one 1 cycle after its push; level returns to 0.
2. **Stall request:** `DEPTH=16`, `AFULL_THR=12`, `wb_out_rdy=0`, push 12 → `wb_stall_req` rises on the edge after the 12th push. Pop 1 → it falls.
3. **Overflow:** fill 16 with `rdy=0`, push a 17th → dropped, `wb_ovf=1`, level stays 16. Then push and pop together → level 16, no new overflow, order preserved.
4. **Last pulse:** push vectors A, B, C with C.`data_vect_last=1`, toggle `rdy` 1,0,1,1 → A, B, C emitted in order, `wb_out_vect` stable while `rdy=0`, `wb_last_done` pulses once, the cycle after C pops.
5. **Clear and reset:** with level 5, assert `wb_clear` together with a push → next cycle level 0, `wb_out_val=0`, `wb_ovf=0`. Assert `rst_n` low mid-stream → outputs are 0 immediately.
6. **Stats (`PIPE_WB_FIFO_STATS_EN`):** reach level 9, drain to 0 → `wb_level_max=9`. After `wb_clear` → 0.
